disp_trigger_decim: RTL and testbench

- Sample-source stage directly upstream of the sparse sample renderer, in the sampling clock domain.
- Takes the raw ADC stream and waits for the renderer to request a capture (smpl_req high).
- Arms an edge trigger with hysteresis, then streams box-car averaged (decimated) samples on smpl/smpl_valid until the renderer drops smpl_req.
- Gives the display a stable, triggered waveform at a selectable timebase.

---
 rtl/disp_trigger_decim.sv | 178 +++++++++++++++++
 tb/tb_disp_trigger_decim.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_trigger_decim.sv
// disp_trigger_decim: edge trigger with hysteresis followed by a box-car decimator feeding the sample renderer.
// Optional auto trigger after AUTO_TIMEOUT armed samples is enabled by defining DISP_TRIG_AUTO_EN.
module disp_trigger_decim #(
  parameter int unsigned DMAX = 8,
  parameter logic [15:0] HYST = 16'h0040
`ifdef DISP_TRIG_AUTO_EN
  ,parameter int unsigned AUTO_TIMEOUT = 65536
`endif
) (
  input  logic        clkSmpl,
  input  logic        reset,
  input  logic        adc_valid,
  input  logic [15:0] adc_data,
  input  logic [15:0] trig_level,
  input  logic        trig_rising,
  input  logic [3:0]  decim,
  input  logic        smpl_req,
  output logic        smpl_valid,
  output logic [15:0] smpl,
  output logic        triggered
);

  localparam int unsigned DW = $clog2(DMAX + 1);
  localparam int unsigned CW = DMAX + 1;
  localparam int unsigned AW = 16 + DMAX;

  typedef enum logic [1:0] {IDLE, ARM, STREAM} state_t;

  state_t        state_q, state_d;
  logic [15:0]   level_q, level_d;
  logic          rising_q, rising_d;
  logic [DW-1:0] d_q, d_d;
  logic          flag_q, flag_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   smpl_q, smpl_d;
  logic          smpl_valid_q, smpl_valid_d;
  logic          triggered_q, triggered_d;

  logic [DW-1:0] decim_clamped;
  logic [15:0]   thr_lo, thr_hi;
  logic [16:0]   hi_sum;
  logic [AW-1:0] acc_sum;
  logic [CW-1:0] cnt_inc;
  logic          blk_done, edge_hit, flag_hit, force_arm, take;

`ifdef DISP_TRIG_AUTO_EN
  localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign force_arm = (tmo_q == TW'(AUTO_TIMEOUT - 1));
`else
  assign force_arm = 1'b0;
`endif

  assign decim_clamped = (32'(decim) > DMAX) ? DW'(DMAX) : DW'(decim);

  // Hysteresis thresholds, saturated at the code range limits
  assign thr_lo   = (level_q >= HYST) ? (level_q - HYST) : 16'h0000;
  assign hi_sum   = {1'b0, level_q} + {1'b0, HYST};
  assign thr_hi   = hi_sum[16] ? 16'hFFFF : hi_sum[15:0];
  assign flag_hit = rising_q ? (adc_data < thr_lo) : (adc_data > thr_hi);
  assign edge_hit = flag_q && (rising_q ? (adc_data >= level_q) : (adc_data <= level_q));

  assign acc_sum  = acc_q + AW'(adc_data);
  assign cnt_inc  = cnt_q + CW'(1);
  assign blk_done = (cnt_inc == (CW'(1) << d_q));

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    rising_d     = rising_q;
    d_d          = d_q;
    flag_d       = flag_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    smpl_d       = smpl_q;
    smpl_valid_d = 1'b0;
    triggered_d  = triggered_q;
    take         = 1'b0;
`ifdef DISP_TRIG_AUTO_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        acc_d       = '0;
        cnt_d       = '0;
        triggered_d = 1'b0;
        if (smpl_req) begin
          state_d  = ARM;
          level_d  = trig_level;
          rising_d = trig_rising;
          d_d      = decim_clamped;
          flag_d   = 1'b0;
`ifdef DISP_TRIG_AUTO_EN
          tmo_d    = '0;
`endif
        end
      end
      ARM: begin
        if (!smpl_req) begin
          state_d = IDLE;
        end else if (adc_valid) begin
          if (edge_hit || force_arm) begin
            state_d     = STREAM;
            triggered_d = edge_hit;
            take        = 1'b1;
          end else if (flag_hit) begin
            flag_d = 1'b1;
          end
`ifdef DISP_TRIG_AUTO_EN
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end
      STREAM: begin
        if (!smpl_req) begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          triggered_d = 1'b0;
        end else if (adc_valid) begin
          take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accumulate; on block completion emit the average and restart without losing a sample
    if (take) begin
      if (blk_done) begin
        smpl_d       = 16'(acc_sum >> d_q);
        smpl_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clkSmpl or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      level_q      <= '0;
      rising_q     <= 1'b0;
      d_q          <= '0;
      flag_q       <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      smpl_q       <= '0;
      smpl_valid_q <= 1'b0;
      triggered_q  <= 1'b0;
`ifdef DISP_TRIG_AUTO_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      rising_q     <= rising_d;
      d_q          <= d_d;
      flag_q       <= flag_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      smpl_q       <= smpl_d;
      smpl_valid_q <= smpl_valid_d;
      triggered_q  <= triggered_d;
`ifdef DISP_TRIG_AUTO_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign smpl_valid = smpl_valid_q;
  assign smpl       = smpl_q;
  assign triggered  = triggered_q;

endmodule

// File: tb/tb_disp_trigger_decim.sv
// tb_disp_trigger_decim: directed and randomized stimulus checked against a queue-based reference model.
module tb_disp_trigger_decim;

  localparam int HYST = 'h40;
  localparam int DMAX = 8;
  localparam int TMO  = 16;
`ifdef DISP_TRIG_AUTO_EN
  localparam bit AUTO_ON = 1'b1;
`else
  localparam bit AUTO_ON = 1'b0;
`endif

  logic        clkSmpl = 1'b0;
  logic        reset = 1'b1;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_data = '0;
  logic [15:0] trig_level = '0;
  logic        trig_rising = 1'b0;
  logic [3:0]  decim = '0;
  logic        smpl_req = 1'b0;
  logic        smpl_valid;
  logic [15:0] smpl;
  logic        triggered;

  always #5 clkSmpl = ~clkSmpl;

`ifdef DISP_TRIG_AUTO_EN
  disp_trigger_decim #(.DMAX(DMAX), .HYST(16'(HYST)), .AUTO_TIMEOUT(TMO)) dut (
`else
  disp_trigger_decim #(.DMAX(DMAX), .HYST(16'(HYST))) dut (
`endif
    .clkSmpl(clkSmpl), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
    .trig_level(trig_level), .trig_rising(trig_rising), .decim(decim), .smpl_req(smpl_req),
    .smpl_valid(smpl_valid), .smpl(smpl), .triggered(triggered)
  );

  // Reference model state: mode 0=idle, 1=armed, 2=streaming
  int m_mode, m_level, m_d, m_tmo, m_smpl;
  bit m_rising, m_flag, m_valid, m_trig;
  int m_blk[$];
  int n_chk = 0, n_pass = 0, n_strobe = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_flag = 0; m_tmo = 0; m_smpl = 0; m_valid = 0; m_trig = 0;
    m_blk.delete();
  endtask

  task automatic model_edge();
    bit take, hit;
    int lo, hi, sum, x;
    if (reset) begin
      model_reset();
      return;
    end
    m_valid = 0;
    take = 0;
    x = int'(adc_data);
    case (m_mode)
      0: if (smpl_req) begin
        m_mode = 1; m_level = int'(trig_level); m_rising = trig_rising;
        m_d = (int'(decim) > DMAX) ? DMAX : int'(decim);
        m_flag = 0; m_tmo = 0;
      end
      1: if (!smpl_req) m_mode = 0;
      else if (adc_valid) begin
        lo = m_level - HYST; if (lo < 0) lo = 0;
        hi = m_level + HYST; if (hi > 65535) hi = 65535;
        hit = m_flag && (m_rising ? (x >= m_level) : (x <= m_level));
        if (hit || (AUTO_ON && (m_tmo + 1 == TMO))) begin
          m_mode = 2; m_trig = hit || !AUTO_ON; take = 1;
        end else if (m_rising ? (x < lo) : (x > hi)) m_flag = 1;
        m_tmo++;
      end
      default: if (!smpl_req) begin
        m_mode = 0; m_trig = 0; m_blk.delete();
      end else if (adc_valid) take = 1;
    endcase
    if (take) begin
      m_blk.push_back(x);
      if (m_blk.size() == (1 << m_d)) begin
        sum = 0;
        foreach (m_blk[i]) sum += m_blk[i];
        m_smpl = sum / (1 << m_d);
        m_valid = 1;
        m_blk.delete();
      end
    end
  endtask

  task automatic step();
    @(posedge clkSmpl);
    model_edge();
    #1;
    if (smpl_valid) n_strobe++;
    check("smpl_valid", int'(smpl_valid), int'(m_valid));
    check("smpl", int'(smpl), m_smpl);
    check("triggered", int'(triggered), int'(m_trig));
  endtask

  task automatic drive(input bit req, input bit v, input logic [15:0] d);
    smpl_req = req; adc_valid = v; adc_data = d;
    step();
  endtask

  task automatic arm(input logic [15:0] lvl, input bit rise, input logic [3:0] dc);
    drive(0, 0, 0); drive(0, 0, 0);
    trig_level = lvl; trig_rising = rise; decim = dc;
    drive(1, 0, 0);
  endtask

  initial begin
    logic [15:0] hseq [4];
    hseq[0] = 16'h7FF0; hseq[1] = 16'h8001; hseq[2] = 16'h7FF0; hseq[3] = 16'h8001;
    model_reset();
    repeat (2) step();
    reset = 1'b0;

    // Rising edge, pass-through
    arm(16'h8000, 1, 0);
    for (int v = 'h7000; v <= 'h9000; v += 'h100) begin
      drive(1, 1, 16'(v));
      if (v == 'h8000) check("first_smpl", int'(smpl), 'h8000);
    end
    trig_level = 16'h0100; decim = 4'd3;
    drive(1, 1, 16'h1234);
    check("hold_params", int'(smpl), 'h1234);

    // Hysteresis: small excursions never arm the edge
    arm(16'h8000, 1, 0);
    n_strobe = 0;
    foreach (hseq[i]) drive(1, 1, hseq[i]);
    check("hyst_no_trig", n_strobe, 0);
    drive(1, 1, 16'h7F00);
    drive(1, 1, 16'h8000);
    check("hyst_trig", n_strobe, 1);

    // Averaging d=2 on a falling edge at level 4
    arm(16'h0004, 0, 2);
    n_strobe = 0;
    drive(1, 1, 16'h0100);
    drive(1, 1, 4); drive(1, 0, 0); drive(1, 1, 8); drive(1, 1, 12); drive(1, 1, 16);
    check("avg_first", int'(smpl), 10);
    repeat (4) drive(1, 1, 16'hFFFF);
    check("avg_last", int'(smpl), 'hFFFF);
    check("avg_strobes", n_strobe, 2);

    // decim above DMAX clamps to 256-sample blocks
    arm(16'h8000, 1, 15);
    drive(1, 1, 16'h7000);
    n_strobe = 0;
    drive(1, 1, 16'h9000);
    for (int k = 1; k < 512; k++) begin
      while ($urandom_range(0, 3) == 0) drive(1, 0, 16'($urandom));
      drive(1, 1, 16'($urandom));
    end
    drive(1, 0, 0);
    check("d15_strobes", n_strobe, 2);

    // Request drop mid-block discards the partial block
    arm(16'h0004, 0, 2);
    drive(1, 1, 16'h0100); drive(1, 1, 4); drive(1, 1, 8);
    n_strobe = 0;
    drive(0, 1, 12); drive(0, 1, 16); drive(0, 0, 0);
    check("drop_no_strobe", n_strobe, 0);
    arm(16'h8000, 1, 0);
    drive(1, 1, 16'h7000); drive(1, 1, 16'h8000);
    check("rearm_smpl", int'(smpl), 'h8000);

    // No edge: auto trigger (if built) on the 16th armed sample
    arm(16'h8000, 1, 0);
    n_strobe = 0;
    repeat (40) drive(1, 1, 16'h1000);
    check("auto_strobes", n_strobe, AUTO_ON ? 25 : 0);

    // Asynchronous reset mid-stream
    arm(16'h8000, 1, 0);
    drive(1, 1, 16'h7000); drive(1, 1, 16'h8000); drive(1, 1, 16'h8100);
    #3 reset = 1'b1;
    #1;
    check("rst_valid", int'(smpl_valid), 0);
    check("rst_smpl", int'(smpl), 0);
    check("rst_trig", int'(triggered), 0);
    model_reset();
    drive(1, 1, 16'h8000);
    reset = 1'b0;
    drive(1, 1, 16'h8000); drive(1, 1, 16'h7000); drive(1, 1, 16'h8000);

    // Randomized traffic, including parameter changes while armed
    for (int c = 0; c < 20000; c++) begin
      if (smpl_req) begin
        if ($urandom_range(0, 299) == 0) smpl_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) smpl_req = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: trig_level = 16'($urandom_range(0, 'h30));
          1: trig_level = 16'('hFFFF - $urandom_range(0, 'h30));
          default: trig_level = 16'($urandom);
        endcase
        trig_rising = 1'($urandom);
        decim = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      end
      adc_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) adc_data = 16'($urandom);
      else adc_data = 16'(int'(trig_level) + int'($urandom_range(0, 'h200)) - 'h100);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
